// File: rtl/vga_pkg.sv
// Shared definitions for the VGA output path: 640x480@60 timing, axis
// state encoding, the sync/blank bundle carried through the alignment
// pipeline, and colour constants used by the colour generator.
package vga_pkg;

  // Counter width for both axes; every axis total must stay below 1024
  localparam int CNT_W = 10;

  // Horizontal timing, in pixel clocks
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

  // Vertical timing, in lines
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  // Default colour-generator latency in clocks (legal range 1..4)
  localparam int VGA_COLOR_LAT = 1;

  // Colour channel width and the shared extreme values
  localparam int COLOR_W = 8;
  localparam logic [COLOR_W-1:0] COLOR_OFF  = 8'h00;
  localparam logic [COLOR_W-1:0] COLOR_FULL = 8'hFF;

  // Phase of one raster axis: active, front porch, sync, back porch
  typedef enum logic [1:0] {
    ACT = 2'd0,
    FPO = 2'd1,
    SYN = 2'd2,
    BPO = 2'd3
  } axis_state_t;

  // Sync/blank bundle travelling alongside the pixel coordinates
  typedef struct packed {
    logic hs;
    logic vs;
    logic visible;
  } sync_bits_t;

  // Idle bundle: both syncs released, pixel blanked
  localparam sync_bits_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, visible: 1'b0};

  // Last count index of a segment that ends after 'len' clocks
  function automatic logic [CNT_W-1:0] last_index(input int len);
    return CNT_W'(len - 1);
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Bus between the timing generator, the colour generator and the VGA
// connector. The master modport is the timing generator; the slave
// modport is whatever consumes coordinates and returns colour.
interface vga_timing_gen_if;
  import vga_pkg::*;

  // Colour returned by the colour generator
  logic [COLOR_W-1:0] i_Red;
  logic [COLOR_W-1:0] i_Green;
  logic [COLOR_W-1:0] i_Blue;

  // Coordinate request side
  logic [CNT_W-1:0]   o_x_pos;
  logic [CNT_W-1:0]   o_y_pos;
  logic               o_frame_start;

  // Connector / DAC pins
  logic               o_VGA_HS;
  logic               o_VGA_VS;
  logic               o_VGA_BLANK_N;
  logic               o_VGA_SYNC_N;
  logic               o_VGA_CLK;
  logic [COLOR_W-1:0] o_VGA_R;
  logic [COLOR_W-1:0] o_VGA_G;
  logic [COLOR_W-1:0] o_VGA_B;

  modport master (
    input  i_Red, i_Green, i_Blue,
    output o_x_pos, o_y_pos, o_frame_start,
    output o_VGA_HS, o_VGA_VS, o_VGA_BLANK_N, o_VGA_SYNC_N, o_VGA_CLK,
    output o_VGA_R, o_VGA_G, o_VGA_B
  );

  modport slave (
    output i_Red, i_Green, i_Blue,
    input  o_x_pos, o_y_pos, o_frame_start,
    input  o_VGA_HS, o_VGA_VS, o_VGA_BLANK_N, o_VGA_SYNC_N, o_VGA_CLK,
    input  o_VGA_R, o_VGA_G, o_VGA_B
  );

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: a wrapping counter plus a four-phase state machine
// (active, front porch, sync, back porch). Used once for the horizontal
// axis (always enabled) and once for the vertical axis (enabled on the
// horizontal wrap). All phase changes compare against the count.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int ACTIVE = VGA_H_ACTIVE,
  parameter int FP     = VGA_H_FP,
  parameter int SYNC   = VGA_H_SYNC,
  parameter int BP     = VGA_H_BP
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output axis_state_t      state,
  output logic             wrap
);

  localparam int TOTAL = ACTIVE + FP + SYNC + BP;

  // Last count value of each phase
  localparam logic [CNT_W-1:0] ACT_LAST = last_index(ACTIVE);
  localparam logic [CNT_W-1:0] FPO_LAST = last_index(ACTIVE + FP);
  localparam logic [CNT_W-1:0] SYN_LAST = last_index(ACTIVE + FP + SYNC);
  localparam logic [CNT_W-1:0] TOT_LAST = last_index(TOTAL);

  axis_state_t      state_q;
  axis_state_t      state_d;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             at_last;

  assign at_last = (count_q == TOT_LAST);

  // State and count registers; reset parks the axis at the start of active
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ACT;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Next count and phase; nothing moves unless the axis is enabled
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (enable) begin
      count_d = at_last ? '0 : count_q + CNT_W'(1);
      unique case (state_q)
        ACT: if (count_q == ACT_LAST) state_d = FPO;
        FPO: if (count_q == FPO_LAST) state_d = SYN;
        SYN: if (count_q == SYN_LAST) state_d = BPO;
        BPO: if (at_last)             state_d = ACT;
        default:                      state_d = ACT;
      endcase
    end
  end

  assign count = count_q;
  assign state = state_q;
  assign wrap  = enable && at_last;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster master. Two axis counters produce the pixel position; the
// position is registered out to the colour generator together with a
// raw sync/blank bundle. That bundle is delayed by the colour latency so
// that, one register later, sync, blank and colour for the same pixel
// reach the connector in the same clock.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE  = VGA_H_ACTIVE,
  parameter int H_FP      = VGA_H_FP,
  parameter int H_SYNC    = VGA_H_SYNC,
  parameter int H_BP      = VGA_H_BP,
  parameter int V_ACTIVE  = VGA_V_ACTIVE,
  parameter int V_FP      = VGA_V_FP,
  parameter int V_SYNC    = VGA_V_SYNC,
  parameter int V_BP      = VGA_V_BP,
  parameter int COLOR_LAT = VGA_COLOR_LAT
) (
  input  logic             i_clk,
  input  logic             i_rst,
  vga_timing_gen_if.master vga
);

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  axis_state_t      h_state;
  axis_state_t      v_state;
  logic             h_wrap;
  logic             v_wrap;

  // Set exactly while both counters sit at zero
  logic             at_origin;

  sync_bits_t       raw_sync;
  sync_bits_t       sync_dly [COLOR_LAT];
  sync_bits_t       pin_sync;

  // Horizontal axis advances every pixel clock
  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP)
  ) u_h_axis (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .enable (1'b1),
    .count  (h_cnt),
    .state  (h_state),
    .wrap   (h_wrap)
  );

  // Vertical axis advances once per line, on the horizontal wrap
  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP)
  ) u_v_axis (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .enable (h_wrap),
    .count  (v_cnt),
    .state  (v_state),
    .wrap   (v_wrap)
  );

  // Both counters reach zero together on the last pixel of the frame
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      at_origin <= 1'b1;
    end else begin
      at_origin <= v_wrap;
    end
  end

  // Coordinate request stage and the raw sync/blank bundle for that pixel
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      vga.o_x_pos       <= '0;
      vga.o_y_pos       <= '0;
      vga.o_frame_start <= 1'b0;
      raw_sync          <= SYNC_IDLE;
    end else begin
      vga.o_x_pos       <= (h_state == ACT) ? h_cnt : '0;
      vga.o_y_pos       <= (v_state == ACT) ? v_cnt : '0;
      vga.o_frame_start <= at_origin;
      raw_sync.hs       <= (h_state != SYN);
      raw_sync.vs       <= (v_state != SYN);
      raw_sync.visible  <= (h_state == ACT) && (v_state == ACT);
    end
  end

  // Hold sync/blank back until the colour for the same pixel has returned
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < COLOR_LAT; i++) begin
        sync_dly[i] <= SYNC_IDLE;
      end
    end else begin
      sync_dly[0] <= raw_sync;
      for (int i = 1; i < COLOR_LAT; i++) begin
        sync_dly[i] <= sync_dly[i-1];
      end
    end
  end

  assign pin_sync = sync_dly[COLOR_LAT-1];

  // Pin register: colour passes only for visible pixels, black otherwise
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      vga.o_VGA_HS      <= 1'b1;
      vga.o_VGA_VS      <= 1'b1;
      vga.o_VGA_BLANK_N <= 1'b0;
      vga.o_VGA_R       <= COLOR_OFF;
      vga.o_VGA_G       <= COLOR_OFF;
      vga.o_VGA_B       <= COLOR_OFF;
    end else begin
      vga.o_VGA_HS      <= pin_sync.hs;
      vga.o_VGA_VS      <= pin_sync.vs;
      vga.o_VGA_BLANK_N <= pin_sync.visible;
      vga.o_VGA_R       <= pin_sync.visible ? vga.i_Red   : COLOR_OFF;
      vga.o_VGA_G       <= pin_sync.visible ? vga.i_Green : COLOR_OFF;
      vga.o_VGA_B       <= pin_sync.visible ? vga.i_Blue  : COLOR_OFF;
    end
  end

  // No sync-on-green; the DAC clock is the pixel clock itself
  assign vga.o_VGA_SYNC_N = 1'b0;
  assign vga.o_VGA_CLK    = i_clk;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen using a reduced raster (330x13,
// colour latency 2) so whole frames fit in a short run. A registered
// colour generator returns x/y as red/green; expectations come from the
// raster geometry and the coordinate-to-pin latency of COLOR_LAT+1.
module tb_vga_timing_gen;
  import vga_pkg::*;

  localparam int HA    = 300;
  localparam int HF    = 8;
  localparam int HSW   = 12;
  localparam int HB    = 10;
  localparam int VA    = 6;
  localparam int VF    = 2;
  localparam int VSW   = 2;
  localparam int VB    = 3;
  localparam int LAT   = 2;
  localparam int HT    = HA + HF + HSW + HB;
  localparam int VT    = VA + VF + VSW + VB;
  localparam int FRAME = HT * VT;
  localparam int SCAN  = 2 * FRAME + 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic force_ff = 1'b0;

  int tests_run    = 0;
  int tests_failed = 0;

  vga_timing_gen_if vga_bus ();

  vga_timing_gen #(
    .H_ACTIVE  (HA),
    .H_FP      (HF),
    .H_SYNC    (HSW),
    .H_BP      (HB),
    .V_ACTIVE  (VA),
    .V_FP      (VF),
    .V_SYNC    (VSW),
    .V_BP      (VB),
    .COLOR_LAT (LAT)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .vga   (vga_bus)
  );

  always #20 clk = ~clk;

  // Registered colour generator with LAT clocks of latency
  logic [7:0] red_pipe [LAT];
  logic [7:0] grn_pipe [LAT];

  always @(posedge clk) begin
    red_pipe[0] <= vga_bus.o_x_pos[7:0];
    grn_pipe[0] <= vga_bus.o_y_pos[7:0];
    for (int i = 1; i < LAT; i++) begin
      red_pipe[i] <= red_pipe[i-1];
      grn_pipe[i] <= grn_pipe[i-1];
    end
  end

  assign vga_bus.i_Red   = force_ff ? 8'hFF : red_pipe[LAT-1];
  assign vga_bus.i_Green = force_ff ? 8'hFF : grn_pipe[LAT-1];
  assign vga_bus.i_Blue  = force_ff ? 8'hFF : 8'hA5;

  // Measurements from one scan
  int model_diffs, first_fall, second_fall, hs_low_len, vs_low_len;
  int blank_run, fs_second, blank_hi_frame, hs_falls_frame;
  logic [7:0]  r_at_255, r_at_256;
  logic [63:0] wrap_vec;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rst_val, input logic force_val);
    rst      = rst_val;
    force_ff = force_val;
  endtask

  function automatic logic [63:0] packVec(input int x, input int y, input logic fs,
                                          input logic hs, input logic vs, input logic bl,
                                          input int r, input int g, input int b);
    return {15'd0, 10'(x), 10'(y), fs, hs, vs, bl, 1'b0, 8'(r), 8'(g), 8'(b)};
  endfunction

  function automatic logic [63:0] pinVec();
    return {15'd0, vga_bus.o_x_pos, vga_bus.o_y_pos, vga_bus.o_frame_start,
            vga_bus.o_VGA_HS, vga_bus.o_VGA_VS, vga_bus.o_VGA_BLANK_N,
            vga_bus.o_VGA_SYNC_N, vga_bus.o_VGA_R, vga_bus.o_VGA_G, vga_bus.o_VGA_B};
  endfunction

  // Expected outputs n clocks after reset release (sampled after edge n)
  function automatic logic [63:0] modelVec(input int n);
    int p, q, h, v, hq, vq;
    logic vis;
    p = n - 1;
    h = p % HT;
    v = (p / HT) % VT;
    q = n - 1 - (LAT + 1);
    if (q < 0)
      return packVec((h < HA) ? h : 0, (v < VA) ? v : 0, (h == 0 && v == 0),
                     1'b1, 1'b1, 1'b0, 0, 0, 0);
    hq  = q % HT;
    vq  = (q / HT) % VT;
    vis = (hq < HA) && (vq < VA);
    return packVec((h < HA) ? h : 0, (v < VA) ? v : 0, (h == 0 && v == 0),
                   !(hq >= HA + HF && hq < HA + HF + HSW),
                   !(vq >= VA + VF && vq < VA + VF + VSW),
                   vis, vis ? (hq % 256) : 0, vis ? (vq % 256) : 0, vis ? 8'hA5 : 0);
  endfunction

  // Run n_cycles clocks from reset release, comparing against the model
  task automatic runScan(input int n_cycles);
    logic prev_hs, prev_vs, prev_bl;
    int hs_start, vs_start, bl_start, q;
    logic [63:0] obs, exp_v;
    model_diffs = 0; first_fall = -1; second_fall = -1; hs_low_len = -1;
    vs_low_len = -1; blank_run = -1; fs_second = -1; blank_hi_frame = 0;
    hs_falls_frame = 0; r_at_255 = 8'h11; r_at_256 = 8'h11; wrap_vec = '1;
    prev_hs = 1'b1; prev_vs = 1'b1; prev_bl = 1'b0;
    hs_start = -1; vs_start = -1; bl_start = -1;
    for (int n = 1; n <= n_cycles; n++) begin
      @(negedge clk);
      obs   = pinVec();
      exp_v = modelVec(n);
      if (obs !== exp_v) begin
        model_diffs++;
        if (model_diffs <= 3)
          $display("[TB] cycle %0d: pins %0h model %0h", n, obs, exp_v);
      end
      q = n - 1 - (LAT + 1);
      if (prev_hs && !vga_bus.o_VGA_HS) begin
        if (first_fall < 0) first_fall = n;
        else if (second_fall < 0) second_fall = n;
        if (q >= 0 && q < FRAME) hs_falls_frame++;
        hs_start = n;
      end
      if (!prev_hs && vga_bus.o_VGA_HS && hs_start >= 0 && hs_low_len < 0)
        hs_low_len = n - hs_start;
      if (prev_vs && !vga_bus.o_VGA_VS) vs_start = n;
      if (!prev_vs && vga_bus.o_VGA_VS && vs_start >= 0 && vs_low_len < 0)
        vs_low_len = n - vs_start;
      if (!prev_bl && vga_bus.o_VGA_BLANK_N) bl_start = n;
      if (prev_bl && !vga_bus.o_VGA_BLANK_N && bl_start >= 0 && blank_run < 0)
        blank_run = n - bl_start;
      if (vga_bus.o_VGA_BLANK_N && q >= 0 && q < FRAME) blank_hi_frame++;
      if (vga_bus.o_frame_start && n > 1 && fs_second < 0) fs_second = n;
      if (q == 255) r_at_255 = vga_bus.o_VGA_R;
      if (q == 256) r_at_256 = vga_bus.o_VGA_R;
      if (n == FRAME + 1)
        wrap_vec = {vga_bus.o_x_pos, vga_bus.o_y_pos, vga_bus.o_frame_start};
      prev_hs = vga_bus.o_VGA_HS;
      prev_vs = vga_bus.o_VGA_VS;
      prev_bl = vga_bus.o_VGA_BLANK_N;
    end
  endtask

  // Compare the scan measurements against hand-derived raster figures
  task automatic checkScan(input string ph);
    checkOutput({ph, "_model_diffs"},   model_diffs, 0);
    checkOutput({ph, "_first_hs_fall"}, first_fall, LAT + 1 + HA + HF + 1);
    checkOutput({ph, "_hs_period"},     second_fall - first_fall, HT);
    checkOutput({ph, "_hs_low_len"},    hs_low_len, HSW);
    checkOutput({ph, "_vs_low_len"},    vs_low_len, VSW * HT);
    checkOutput({ph, "_blank_run"},     blank_run, HA);
    checkOutput({ph, "_frame_period"},  fs_second, FRAME + 1);
    checkOutput({ph, "_blank_hi_cnt"},  blank_hi_frame, HA * VA);
    checkOutput({ph, "_lines_per_frm"}, hs_falls_frame, VT);
    checkOutput({ph, "_red_x255"},      r_at_255, 8'd255);
    checkOutput({ph, "_red_x256"},      r_at_256, 8'd0);
    checkOutput({ph, "_wrap_xyfs"},     wrap_vec, {10'd0, 10'd0, 1'b1});
  endtask

  initial begin
    int leak, vis_bad, found;
    applyStimulus(1'b1, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("reset_state", pinVec(), packVec(0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 0));

    applyStimulus(1'b0, 1'b0);
    runScan(SCAN);
    checkScan("scan1");

    // Saturated colour in: must reach the pins only while visible
    applyStimulus(1'b0, 1'b1);
    repeat (LAT + 4) @(negedge clk);
    leak = 0; vis_bad = 0;
    for (int i = 0; i < 2 * HT; i++) begin
      @(negedge clk);
      if (!vga_bus.o_VGA_BLANK_N && vga_bus.o_VGA_R != 8'h00) leak++;
      if (vga_bus.o_VGA_BLANK_N && vga_bus.o_VGA_R != 8'hFF) vis_bad++;
    end
    checkOutput("force_blank_leak", leak, 0);
    checkOutput("force_visible_ff", vis_bad, 0);
    applyStimulus(1'b0, 1'b0);

    // Reset in the middle of a frame at pixel (150,3)
    found = 0;
    for (int i = 0; i < 2 * FRAME && found == 0; i++) begin
      @(negedge clk);
      if (vga_bus.o_x_pos == 10'd150 && vga_bus.o_y_pos == 10'd3) found = 1;
    end
    checkOutput("wait_pixel_150_3", found, 1);
    #5;
    applyStimulus(1'b1, 1'b0);
    #1;
    checkOutput("async_reset", pinVec(), packVec(0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 0));
    repeat (3) @(posedge clk);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0);
    runScan(SCAN);
    checkScan("scan2");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
